// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the unified instruction/data memory port arbiter.
package mem_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STAT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_e;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin picker; bit 0 is fetch, bit 1 is data. Owns the last-grant pointer.
module mem_arb_rr2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    port_e last_q, last_d;

    always_comb begin
        gnt    = 2'b00;
        last_d = last_q;
        if (advance) begin
            // On a tie the port that did not win last time goes first.
            if (req == 2'b11) begin
                gnt = (last_q == PORT_D) ? 2'b01 : 2'b10;
            end else if (req[0]) begin
                gnt = 2'b01;
            end else if (req[1]) begin
                gnt = 2'b10;
            end
        end
        if (gnt[0]) begin
            last_d = PORT_IF;
        end else if (gnt[1]) begin
            last_d = PORT_D;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= PORT_D;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Sequencer/arbiter sharing one single-port memory between fetch and load/store.
// Optional statistics counters are built when MEM_ARB_STATS_EN is defined.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int INSTR_MEM_SIZE = 32,
    parameter int DATA_MEM_SIZE  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,
`ifdef MEM_ARB_STATS_EN
    output logic [STAT_W-1:0] stat_if_cnt,
    output logic [STAT_W-1:0] stat_d_cnt,
    output logic [STAT_W-1:0] stat_conflict_cnt,
`endif
    output logic              busy
);

    arb_state_e        state_q, state_d;
    port_e             port_q;
    logic              err_q;
    logic              we_q;
    logic [ADDR_W-1:0] maddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic              advance;
    logic [1:0]        gnt_w;
    logic              sel_d;
    logic [ADDR_W-1:0] g_addr;
    logic [ADDR_W-1:0] g_word;
    logic [ADDR_W-1:0] g_limit;
    logic              g_err;

    // Grants are suppressed while rst is high so every output reads 0 in reset.
    assign advance = (state_q == ST_IDLE) && !rst;

    mem_arb_rr2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     ({d_req, if_req}),
        .advance (advance),
        .gnt     (gnt_w)
    );

    assign if_gnt  = gnt_w[0];
    assign d_gnt   = gnt_w[1];
    assign sel_d   = gnt_w[1];
    assign g_addr  = sel_d ? d_addr : if_addr;
    assign g_word  = {2'b00, g_addr[ADDR_W-1:2]};
    assign g_limit = sel_d ? ADDR_W'(DATA_MEM_SIZE) : ADDR_W'(INSTR_MEM_SIZE);
    assign g_err   = (g_addr[1:0] != 2'b00) || (g_word >= g_limit);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (|gnt_w) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            port_q  <= PORT_IF;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            maddr_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && (|gnt_w)) begin
                port_q  <= sel_d ? PORT_D : PORT_IF;
                err_q   <= g_err;
                we_q    <= sel_d && d_we && !g_err;
                wdata_q <= sel_d ? d_wdata : '0;
                // Data words live above the instruction region in the unified memory.
                if (g_err) begin
                    maddr_q <= '0;
                end else if (sel_d) begin
                    maddr_q <= ADDR_W'(INSTR_MEM_SIZE) + g_word;
                end else begin
                    maddr_q <= g_word;
                end
            end
            if (state_q == ST_ACCESS) begin
                rdata_q <= (err_q || we_q) ? '0 : mem_rd;
            end
        end
    end

    assign mem_addr  = (state_q == ST_ACCESS) ? maddr_q : '0;
    assign mem_we    = (state_q == ST_ACCESS) && we_q;
    assign mem_wd    = (state_q == ST_ACCESS) ? wdata_q : '0;
    assign if_rvalid = (state_q == ST_RESP) && (port_q == PORT_IF);
    assign d_rvalid  = (state_q == ST_RESP) && (port_q == PORT_D);
    assign if_rdata  = if_rvalid ? rdata_q : '0;
    assign d_rdata   = d_rvalid ? rdata_q : '0;
    assign if_err    = if_rvalid && err_q;
    assign d_err     = d_rvalid && err_q;
    assign busy      = (state_q != ST_IDLE);

`ifdef MEM_ARB_STATS_EN
    logic [STAT_W-1:0] if_cnt_q, d_cnt_q, conf_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_cnt_q   <= '0;
            d_cnt_q    <= '0;
            conf_cnt_q <= '0;
        end else begin
            if (if_gnt && (if_cnt_q != '1)) if_cnt_q <= if_cnt_q + 1'b1;
            if (d_gnt && (d_cnt_q != '1)) d_cnt_q <= d_cnt_q + 1'b1;
            if (advance && if_req && d_req && (conf_cnt_q != '1)) conf_cnt_q <= conf_cnt_q + 1'b1;
        end
    end

    assign stat_if_cnt       = if_cnt_q;
    assign stat_d_cnt        = d_cnt_q;
    assign stat_conflict_cnt = conf_cnt_q;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequencing controller and two-way arbiter in front of the unified single-port instruction/data memory of the multi-cycle MIPS core.
- Shares that memory between the instruction-fetch requester and the load/store requester.
- Translates byte addresses to word indices and region offsets, and rejects illegal accesses.
- Returns read data and write acks through a registered valid/response handshake.

Parameters:
- INSTR_MEM_SIZE, 32, instruction region size in words; word indices 0..INSTR_MEM_SIZE-1.
- DATA_MEM_SIZE, 32, data region size in words; word indices INSTR_MEM_SIZE..INSTR_MEM_SIZE+DATA_MEM_SIZE-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset (one clock; reset is asynchronous and active-high).
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  32  fetch byte address, instruction-region relative.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  one-cycle fetch response pulse.
- if_rdata  out  32  fetched word; valid with if_rvalid.
- if_err  out  1  fetch response is an error; valid with if_rvalid.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address, data-region relative.
- d_wdata  in  32  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  one-cycle data response pulse; loads and stores both get one.
- d_rdata  out  32  load data; 0 for stores and errors.
- d_err  out  1  data response is an error; valid with d_rvalid.
- mem_addr  out  32  word index to memory.
- mem_we  out  1  memory write enable.
- mem_wd  out  32  memory write data.
- mem_rd  in  32  memory combinational read data.
- busy  out  1  high in every state other than IDLE.

Behaviour:
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. All three transitions are unconditional except IDLE -> ACCESS, which needs a grant.
- Grant in IDLE only:
  - gnt is combinational from state, reqs and the round-robin pointer.
  - At most one gnt per cycle.
  - Address, we and wdata are captured into registers on the gnt cycle.
- Arbitration:
  - Single requester wins.
  - If both request, the port not granted last wins.
  - The last-grant pointer resets to "data", so the first tie goes to fetch.
- Address check on the gnt cycle:
  - Misaligned (addr[1:0] != 0): error.
  - Fetch with addr[31:2] >= INSTR_MEM_SIZE: error.
  - Data with addr[31:2] >= DATA_MEM_SIZE: error.
- ACCESS cycle, legal request:
  - mem_addr = addr[31:2] for fetch; INSTR_MEM_SIZE + addr[31:2] for data.
  - mem_we = d_we for data, always 0 for fetch.
  - mem_wd = captured wdata.
  - mem_rd is latched into the response register at the end of the cycle.
- ACCESS cycle, error request: mem_we = 0, mem_addr = 0, response data forced to 0.
- RESP cycle:
  - Exactly one of if_rvalid / d_rvalid pulses high for one cycle, with the matching rdata and err.
  - Response latency is 2 cycles after gnt.
  - One transaction every 3 cycles, at most one in flight.
- Outputs outside ACCESS: mem_we = 0, mem_addr = 0, mem_wd = 0.
- rvalid, rdata and err hold 0 except in RESP.
- Reset values: every output 0; state IDLE; pointer = data.
- Reset mid-operation: asynchronous return to IDLE, in-flight transaction dropped, no response issued, mem_we deasserts immediately.
- Requests that change before gnt are not legal stimulus. Requests seen while busy are ignored until IDLE.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined, adds three outputs:
  - stat_if_cnt (16): granted fetches.
  - stat_d_cnt (16): granted data requests.
  - stat_conflict_cnt (16): IDLE cycles with both reqs high.
- Counters saturate at 0xFFFF and clear on rst.
- When not defined, the outputs and logic are absent and the ports are identical to the list above.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum typedef (IDLE, ACCESS, RESP);
  - port-id enum (PORT_IF, PORT_D);
  - ADDR_W = 32, DATA_W = 32;
  - STAT_W = 16.
- One sub-module: mem_arb_rr2, the two-way round-robin picker.
  - Inputs: req[1:0], advance, clk, rst.
  - Outputs: one-hot gnt[1:0].
  - Owns the last-grant pointer register.

Test Plan:
- Fetch only: if_req=1, if_addr=0x0000_0010 -> if_gnt in cycle 0; mem_addr=4, mem_we=0 in cycle 1; if_rvalid=1, if_rdata=mem[4], if_err=0 in cycle 2; busy=1 in cycles 1-2.
- Store then load: d_we=1, d_addr=0x8, d_wdata=0xDEADBEEF -> mem_addr=34, mem_we=1 for exactly one cycle, d_rvalid with d_rdata=0. Then a load from 0x8 returns 0xDEADBEEF.
- Conflict: if_req and d_req both high from reset -> fetch granted first, data granted next IDLE. Held together for 4 transactions -> grant order IF,D,IF,D.
- Errors (each -> rvalid with err=1, rdata=0, mem_we never asserted):
  - fetch at if_addr=0x80 (word 32, out of range);
  - data at d_addr=0x6 (misaligned);
  - data at d_addr=0x80.
- Reset during ACCESS of a store: rst asserted mid-cycle -> mem_we falls asynchronously, no rvalid pulses, next request is served normally.
- With MEM_ARB_STATS_EN defined: 3 fetches, 2 stores, 1 conflict cycle -> stat_if_cnt=3, stat_d_cnt=2, stat_conflict_cnt=1; counters saturate at 0xFFFF.
